// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle FP32 add/subtract sequencer built around an
// external shared 24-bit mantissa add/sub datapath.
//
// Flow: IDLE (unpack, swap so |A|>=|B|) -> ALIGN (shift B right) -> ADD
// (one datapath operation) -> NORM (serial normalise) -> DONE (hold result).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid stays high, with
// out_res and the flags stable, until out_ready is seen.
//
// Build option: define FPU_ALIGN_BARREL_EN to do the whole alignment shift
// in a single ALIGN cycle. The default is a serial 1-bit-per-cycle shift.
// Results are identical either way; only the latency changes.
//
// Number handling: exponent 0 is treated as zero, exponent 255 is not
// special-cased, rounding is truncation, and a zero result is always +0.

module fp_addsub_seq #(
    parameter int ALIGN_CLAMP = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [23:0] dp_i0,
    output logic [23:0] dp_i1,
    output logic        dp_cin,
    input  logic [23:0] dp_sum,
    input  logic        dp_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        busy
);

    localparam logic [7:0] CLAMP = 8'(ALIGN_CLAMP);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic        sign_r;
    logic        eff_sub_r;
    logic [7:0]  exp_r;
    logic [23:0] ma_r;
    logic [23:0] mb_r;
    logic [7:0]  d_r;
    logic [23:0] m_r;
    logic        carry_r;

    // Operand unpack: a zero exponent flushes the mantissa to zero.
    logic [7:0]  ea_in;
    logic [7:0]  eb_in;
    logic [23:0] ma_in;
    logic [23:0] mb_in;
    logic        b_bigger;
    logic [7:0]  diff;
    logic [7:0]  d_in;

    assign ea_in    = in_a[30:23];
    assign eb_in    = in_b[30:23];
    assign ma_in    = (ea_in == 8'd0) ? 24'd0 : {1'b1, in_a[22:0]};
    assign mb_in    = (eb_in == 8'd0) ? 24'd0 : {1'b1, in_b[22:0]};
    assign b_bigger = (eb_in > ea_in) || ((eb_in == ea_in) && (mb_in > ma_in));
    assign diff     = b_bigger ? (eb_in - ea_in) : (ea_in - eb_in);
    assign d_in     = (diff >= CLAMP) ? CLAMP : diff;

    // Normalisation helpers: candidate values for one left or right step.
    logic [23:0] m_shl;
    logic [7:0]  e_dec;
    logic [8:0]  e_inc;

    assign m_shl = {m_r[22:0], 1'b0};
    assign e_dec = exp_r - 8'd1;
    assign e_inc = {1'b0, exp_r} + 9'd1;

    // The shared datapath only sees operands during ADD; elsewhere it is fed zeros.
    assign dp_i0  = (state == ADD) ? ma_r : 24'd0;
    assign dp_i1  = (state == ADD) ? mb_r : 24'd0;
    assign dp_cin = (state == ADD) ? eff_sub_r : 1'b0;

    // Sequencer: state, operand registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sign_r    <= 1'b0;
            eff_sub_r <= 1'b0;
            exp_r     <= 8'd0;
            ma_r      <= 24'd0;
            mb_r      <= 24'd0;
            d_r       <= 8'd0;
            m_r       <= 24'd0;
            carry_r   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_res   <= 32'd0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // After the swap A is the larger magnitude; when B becomes
                        // A its effective sign is its own sign flipped by op.
                        sign_r    <= b_bigger ? (in_b[31] ^ op) : in_a[31];
                        eff_sub_r <= in_a[31] ^ in_b[31] ^ op;
                        exp_r     <= b_bigger ? eb_in : ea_in;
                        ma_r      <= b_bigger ? mb_in : ma_in;
                        mb_r      <= b_bigger ? ma_in : mb_in;
                        d_r       <= d_in;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ALIGN;
                    end
                end

                ALIGN: begin
`ifdef FPU_ALIGN_BARREL_EN
                    mb_r  <= mb_r >> d_r;
                    d_r   <= 8'd0;
                    state <= ADD;
`else
                    if (d_r == 8'd0) begin
                        state <= ADD;
                    end else begin
                        mb_r <= mb_r >> 1;
                        d_r  <= d_r - 8'd1;
                        if (d_r == 8'd1) begin
                            state <= ADD;
                        end
                    end
`endif
                end

                ADD: begin
                    // |A|>=|B| means subtraction never borrows, so carry only matters on add.
                    m_r     <= dp_sum;
                    carry_r <= dp_cout & ~eff_sub_r;
                    state   <= NORM;
                end

                NORM: begin
                    if (carry_r) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        if (e_inc >= 9'd255) begin
                            out_res <= {sign_r, 8'hFF, 23'd0};
                            out_ovf <= 1'b1;
                            out_unf <= 1'b0;
                        end else begin
                            out_res <= {sign_r, e_inc[7:0], m_r[23:1]};
                            out_ovf <= 1'b0;
                            out_unf <= 1'b0;
                        end
                    end else if (m_r == 24'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_res   <= 32'd0;
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b0;
                    end else if (m_r[23]) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_res   <= {sign_r, exp_r, m_r[22:0]};
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b0;
                    end else if (e_dec == 8'd0) begin
                        // Exponent ran out before the leading one arrived: flush to +0.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_res   <= 32'd0;
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b1;
                    end else if (m_shl[23]) begin
                        // This shift lands the leading one; finish in the same cycle.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_res   <= {sign_r, e_dec, m_shl[22:0]};
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b0;
                    end else begin
                        m_r   <= m_shl;
                        exp_r <= e_dec;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Testbench for fp_addsub_seq: directed vectors plus a short random mix, an
// arithmetic reference model, a scoreboard queue of expected results and a
// negedge compare process that checks outputs on every meaningful cycle.

module tb_fp_addsub_seq;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [23:0] dp_i0;
    logic [23:0] dp_i1;
    logic        dp_cin;
    logic [23:0] dp_sum;
    logic        dp_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_ovf;
    logic        out_unf;
    logic        busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef FPU_ALIGN_BARREL_EN
    localparam bit ONE_SHOT_ALIGN = 1'b1;
`else
    localparam bit ONE_SHOT_ALIGN = 1'b0;
`endif

    fp_addsub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_a      (in_a),
        .in_b      (in_b),
        .dp_i0     (dp_i0),
        .dp_i1     (dp_i1),
        .dp_cin    (dp_cin),
        .dp_sum    (dp_sum),
        .dp_cout   (dp_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .busy      (busy)
    );

    // Shared mantissa datapath: i0 + i1 or i0 + ~i1 + 1.
    logic [24:0] dp_full;
    assign dp_full = {1'b0, dp_i0} + {1'b0, (dp_cin ? ~dp_i1 : dp_i1)} + 25'(dp_cin);
    assign dp_sum  = dp_full[23:0];
    assign dp_cout = dp_full[24];

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  flag_q[$];
    int          lat_q[$];
    int          acc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on sign/exponent/mantissa.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic o,
                                  output logic [31:0] r, output logic ov, output logic un,
                                  output int lat);
        int ea, eb, ti, d, e, lz, acyc, ncyc;
        longint ma, mb, m, tm, tl;
        bit sa, sb, tbit, s, sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 64'd0 : ((64'd1 << 23) | longint'(a[22:0]));
        mb = (eb == 0) ? 64'd0 : ((64'd1 << 23) | longint'(b[22:0]));
        sa = a[31];
        sb = b[31] ^ o;
        if (eb > ea || (eb == ea && mb > ma)) begin
            ti = ea; ea = eb; eb = ti;
            tl = ma; ma = mb; mb = tl;
            tbit = sa; sa = sb; sb = tbit;
        end
        s   = sa;
        sub = sa ^ sb;
        d   = ea - eb;
        if (d > 26) d = 26;
        mb   = (d >= 24) ? 64'd0 : (mb >> d);
        acyc = ONE_SHOT_ALIGN ? 1 : ((d == 0) ? 1 : d);
        m    = sub ? (ma - mb) : (ma + mb);
        e    = ea;
        ov   = 1'b0;
        un   = 1'b0;
        r    = 32'd0;
        if (m == 0) begin
            ncyc = 1;
        end else if (m >= (64'd1 << 24)) begin
            ncyc = 1;
            if (e + 1 >= 255) begin
                ov = 1'b1;
                r  = {s, 8'hFF, 23'd0};
            end else begin
                r = {s, 8'(e + 1), 23'(m >> 1)};
            end
        end else begin
            lz = 0;
            tm = m;
            while (tm < (64'd1 << 23)) begin
                tm = tm * 2;
                lz++;
            end
            if (lz == 0) begin
                ncyc = 1;
                r = {s, 8'(e), 23'(m)};
            end else if (lz >= e) begin
                ncyc = e;
                un   = 1'b1;
                r    = 32'd0;
            end else begin
                ncyc = lz;
                r = {s, 8'(e - lz), 23'(tm)};
            end
        end
        lat = acyc + 1 + ncyc + 1;
    endfunction

    // ---------------- compare process ----------------
    bit prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("res", out_res, exp_q[0]);
                    check("flags", {30'd0, out_ovf, out_unf}, {30'd0, flag_q[0]});
                    if (!prev_valid) check("latency", 32'(cyc - acc_q[0] + 1), 32'(lat_q[0]));
                    check("ready_in_done", {30'd0, busy, in_ready}, 32'd2);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(flag_q.pop_front());
                        void'(lat_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            if (!busy || out_valid) begin
                check("dp_quiet", 32'(dp_i0 | dp_i1) | 32'(dp_cin), 32'd0);
            end
            if (!busy) begin
                check("idle_ready", {30'd0, in_ready, out_valid}, 32'd2);
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o, input bit expect_res);
        logic [31:0] r;
        logic ov, un;
        int lat;
        bit acc;
        model(a, b, o, r, ov, un, lat);
        in_a     = a;
        in_b     = b;
        op       = o;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int k = 0; k < 300; k++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (expect_res) begin
            exp_q.push_back(r);
            flag_q.push_back({ov, un});
            lat_q.push_back(lat);
            acc_q.push_back(cyc);
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && in_ready) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            flag_q.delete();
            lat_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic pin_model(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic o, input logic [31:0] er, input logic [1:0] ef, input int elat);
        logic [31:0] r;
        logic ov, un;
        int lat;
        model(a, b, o, r, ov, un, lat);
        check({name, "_res"}, r, er);
        check({name, "_flags"}, {30'd0, ov, un}, {30'd0, ef});
        check({name, "_lat"}, 32'(lat), 32'(elat));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra, rb;
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_res", out_res, 32'd0);
        check("rst_flags", {30'd0, out_ovf, out_unf}, 32'd0);
        check("rst_dp", 32'(dp_i0 | dp_i1) | 32'(dp_cin), 32'd0);
        rst = 1'b0;

        // Hand-computed values that pin the reference model.
        pin_model("pin_1p1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2'b00, 4);
        pin_model("pin_1p5m1", 32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 2'b00, 4);
        pin_model("pin_1m1", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b00, 4);
        pin_model("pin_trunc", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 2'b00,
                  ONE_SHOT_ALIGN ? 4 : 27);
        pin_model("pin_ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b10, 4);
        pin_model("pin_unf", 32'h01000000, 32'h00C00000, 1'b1, 32'h00000000, 2'b01,
                  ONE_SHOT_ALIGN ? 5 : 5);
        pin_model("pin_1m2", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 2'b00, 4);

        // Directed vectors through the DUT.
        send(32'h3F800000, 32'h3F800000, 1'b0, 1'b1); wait_drain();
        send(32'h3FC00000, 32'h3F800000, 1'b1, 1'b1); wait_drain();
        send(32'h3F800000, 32'h3F800000, 1'b1, 1'b1); wait_drain();
        send(32'h3F800000, 32'h33800000, 1'b0, 1'b1); wait_drain();
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1); wait_drain();
        send(32'h01000000, 32'h00C00000, 1'b1, 1'b1); wait_drain();
        send(32'h3F800000, 32'h40000000, 1'b1, 1'b1); wait_drain();
        send(32'h40000000, 32'hC0400000, 1'b0, 1'b1); wait_drain();
        send(32'h00000000, 32'hC0000000, 1'b0, 1'b1); wait_drain();
        send(32'h80000000, 32'h00000000, 1'b0, 1'b1); wait_drain();

        // New operands offered while busy must be ignored.
        send(32'h3F800000, 32'h33800000, 1'b0, 1'b1);
        in_a     = 32'h7F7FFFFF;
        in_b     = 32'h12345678;
        op       = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Consumer back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(32'h3FC00000, 32'h3F800000, 1'b0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("hold_seen", 32'(seen), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_res", out_res, 32'h40200000);
        out_ready = 1'b1;
        wait_drain();

        // Reset mid-operation discards it.
        send(32'h3F800000, 32'h33800000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (40) @(posedge clk);
        #1;

        // Short random mix, half with nearby exponents to exercise cancellation.
        for (int k = 0; k < 16; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 2 == 0) rb[30:23] = ra[30:23] - 8'($urandom_range(0, 2));
            send(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
            wait_drain();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
